// File: rtl/cam_array_if.sv
// Request/response bundle for cam_array: write, invalidate, read and search channels.
// Defining CAM_SEARCH_MASK_EN adds the per-bit search mask signal.
interface cam_array_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              write_enable_i;
  logic [ADDR_W-1:0] write_addr_i;
  logic [WIDTH-1:0]  write_data_i;
  logic              invalidate_enable_i;
  logic [ADDR_W-1:0] invalidate_addr_i;
  logic [ADDR_W-1:0] read_addr_i;
  logic [WIDTH-1:0]  read_data_o;
  logic              read_valid_o;
  logic              search_enable_i;
  logic [WIDTH-1:0]  search_data_i;
`ifdef CAM_SEARCH_MASK_EN
  logic [WIDTH-1:0]  search_mask_i;
`endif
  logic              search_done_o;
  logic              search_hit_o;
  logic [ADDR_W-1:0] search_addr_o;
  logic              search_multi_o;
  logic              full_o;
  logic [ADDR_W-1:0] free_addr_o;

  modport master (
    output write_enable_i, write_addr_i, write_data_i,
    output invalidate_enable_i, invalidate_addr_i,
    output read_addr_i,
    output search_enable_i, search_data_i,
`ifdef CAM_SEARCH_MASK_EN
    output search_mask_i,
`endif
    input  read_data_o, read_valid_o,
    input  search_done_o, search_hit_o, search_addr_o, search_multi_o,
    input  full_o, free_addr_o
  );

  modport slave (
    input  write_enable_i, write_addr_i, write_data_i,
    input  invalidate_enable_i, invalidate_addr_i,
    input  read_addr_i,
    input  search_enable_i, search_data_i,
`ifdef CAM_SEARCH_MASK_EN
    input  search_mask_i,
`endif
    output read_data_o, read_valid_o,
    output search_done_o, search_hit_o, search_addr_o, search_multi_o,
    output full_o, free_addr_o
  );
endinterface

// File: rtl/cam_array.sv
// DEPTH x WIDTH content-addressable memory with registered, lowest-index-wins search.
// Optional CAM_SEARCH_MASK_EN makes masked key bits don't-care during search.
module cam_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic       clk,
  input logic       reset,
  cam_array_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] match_addr;
  logic [ADDR_W-1:0] free_addr;
  logic              match_any;
  logic              match_multi;

  logic [WIDTH-1:0]  read_data_q;
  logic              read_valid_q;
  logic              search_done_q;
  logic              search_hit_q;
  logic [ADDR_W-1:0] search_addr_q;
  logic              search_multi_q;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_SEARCH_MASK_EN
      match[i] = valid[i] && (((mem[i] ^ bus.search_data_i) & ~bus.search_mask_i) == '0);
`else
      match[i] = valid[i] && (mem[i] == bus.search_data_i);
`endif
    end
  end

  // Scan from the top down so the lowest index is the last assignment.
  always_comb begin
    match_addr = '0;
    free_addr  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) match_addr = ADDR_W'(i);
      if (!valid[i]) free_addr = ADDR_W'(i);
    end
  end

  assign match_any   = |match;
  assign match_multi = |(match & (match - DEPTH'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid          <= '0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      search_done_q  <= 1'b0;
      search_hit_q   <= 1'b0;
      search_addr_q  <= '0;
      search_multi_q <= 1'b0;
    end else begin
      read_data_q   <= mem[bus.read_addr_i];
      read_valid_q  <= valid[bus.read_addr_i];
      search_done_q <= bus.search_enable_i;
      if (bus.search_enable_i) begin
        search_hit_q   <= match_any;
        search_addr_q  <= match_addr;
        search_multi_q <= match_multi;
      end
      // Write is scheduled after invalidate so it wins on a shared index.
      if (bus.invalidate_enable_i) valid[bus.invalidate_addr_i] <= 1'b0;
      if (bus.write_enable_i) begin
        mem[bus.write_addr_i]   <= bus.write_data_i;
        valid[bus.write_addr_i] <= 1'b1;
      end
    end
  end

  assign bus.read_data_o    = read_data_q;
  assign bus.read_valid_o   = read_valid_q;
  assign bus.search_done_o  = search_done_q;
  assign bus.search_hit_o   = search_hit_q;
  assign bus.search_addr_o  = search_addr_q;
  assign bus.search_multi_o = search_multi_q;
  assign bus.full_o         = &valid;
  assign bus.free_addr_o    = free_addr;
endmodule

// File: tb/tb_cam_array.sv
// Self-checking bench for cam_array: a table model checked every cycle plus directed literal checks.
// Mask tests are compiled in when CAM_SEARCH_MASK_EN is defined.
module tb_cam_array;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  cam_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) cam_if ();

  cam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (cam_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table of entries and a list of valid flags.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_valid [DEPTH];
  bit               started = 0;
  logic [WIDTH-1:0] e_rdata;
  bit               e_rvalid, e_done, e_hit, e_multi;
  int               e_addr;

  function automatic bit model_match(input int idx);
    logic [WIDTH-1:0] care;
    care = '1;
`ifdef CAM_SEARCH_MASK_EN
    care = ~cam_if.search_mask_i;
`endif
    if (!m_valid[idx]) return 0;
    for (int b = 0; b < WIDTH; b++)
      if (care[b] && (m_mem[idx][b] != cam_if.search_data_i[b])) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 0; end
      e_rdata = '0; e_rvalid = 0; e_done = 0; e_hit = 0; e_addr = 0; e_multi = 0;
    end else begin
      int n, first;
      e_rdata  = m_mem[cam_if.read_addr_i];
      e_rvalid = m_valid[cam_if.read_addr_i];
      e_done   = cam_if.search_enable_i;
      if (cam_if.search_enable_i) begin
        n = 0; first = -1;
        for (int i = 0; i < DEPTH; i++)
          if (model_match(i)) begin n++; if (first < 0) first = i; end
        e_hit = (n > 0); e_addr = (first < 0) ? 0 : first; e_multi = (n >= 2);
      end
      if (cam_if.invalidate_enable_i) m_valid[cam_if.invalidate_addr_i] = 0;
      if (cam_if.write_enable_i) begin
        m_mem[cam_if.write_addr_i]   = cam_if.write_data_i;
        m_valid[cam_if.write_addr_i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int nfree;
      bit all;
      all = 1; nfree = 0;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) begin all = 0; nfree = i; end
      chk("m_done", 32'(cam_if.search_done_o), 32'(e_done));
      chk("m_rdata", cam_if.read_data_o, e_rdata);
      chk("m_rvalid", 32'(cam_if.read_valid_o), 32'(e_rvalid));
      chk("m_full", 32'(cam_if.full_o), 32'(all));
      chk("m_free", 32'(cam_if.free_addr_o), 32'(nfree));
      if (e_done) begin
        chk("m_hit", 32'(cam_if.search_hit_o), 32'(e_hit));
        chk("m_addr", 32'(cam_if.search_addr_o), 32'(e_addr));
        chk("m_multi", 32'(cam_if.search_multi_o), 32'(e_multi));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cam_if.write_enable_i      = 1'b0;
    cam_if.invalidate_enable_i = 1'b0;
    cam_if.search_enable_i     = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cam_if.write_enable_i = 1'b1; cam_if.write_addr_i = 4'(a); cam_if.write_data_i = d;
  endtask

  task automatic inv(input int a);
    cam_if.invalidate_enable_i = 1'b1; cam_if.invalidate_addr_i = 4'(a);
  endtask

  task automatic srch(input logic [31:0] k);
    cam_if.search_enable_i = 1'b1; cam_if.search_data_i = k;
  endtask

  task automatic expect_search(input string name, input bit hit, input int addr, input bit multi);
    @(negedge clk);
    chk({name, "_done"}, 32'(cam_if.search_done_o), 32'd1);
    chk({name, "_hit"}, 32'(cam_if.search_hit_o), 32'(hit));
    chk({name, "_addr"}, 32'(cam_if.search_addr_o), 32'(addr));
    chk({name, "_multi"}, 32'(cam_if.search_multi_o), 32'(multi));
  endtask

  initial begin
    reset = 1'b1;
    cam_if.write_enable_i = 1'b0; cam_if.write_addr_i = '0; cam_if.write_data_i = '0;
    cam_if.invalidate_enable_i = 1'b0; cam_if.invalidate_addr_i = '0;
    cam_if.read_addr_i = '0;
    cam_if.search_enable_i = 1'b0; cam_if.search_data_i = '0;
`ifdef CAM_SEARCH_MASK_EN
    cam_if.search_mask_i = '0;
`endif
    repeat (2) step();
    reset = 1'b0;

    srch(32'h0); step();
    expect_search("empty", 0, 0, 0);
    chk("empty_full", 32'(cam_if.full_o), 32'd0);
    chk("empty_free", 32'(cam_if.free_addr_o), 32'd0);

    wr(3, 32'hDEADBEEF); step();
    wr(7, 32'h12345678); step();
    srch(32'h12345678); cam_if.read_addr_i = 4'd3; step();
    expect_search("s7", 1, 7, 0);
    chk("rd3_data", cam_if.read_data_o, 32'hDEADBEEF);
    chk("rd3_valid", 32'(cam_if.read_valid_o), 32'd1);

    wr(3, 32'h11111111); step();
    @(negedge clk);
    chk("rbw_data", cam_if.read_data_o, 32'hDEADBEEF);

    wr(2, 32'hAAAA5555); step();
    wr(9, 32'hAAAA5555); step();
    srch(32'hAAAA5555); step();
    expect_search("dup", 1, 2, 1);
    inv(2); step();
    @(negedge clk);
    chk("hold_done", 32'(cam_if.search_done_o), 32'd0);
    chk("hold_multi", 32'(cam_if.search_multi_o), 32'd1);
    srch(32'hAAAA5555); step();
    expect_search("dup_inv", 1, 9, 0);

    wr(5, 32'hCAFEF00D); srch(32'hCAFEF00D); step();
    expect_search("same_cyc", 0, 0, 0);
    srch(32'hCAFEF00D); step();
    expect_search("next_cyc", 1, 5, 0);
    wr(5, 32'hCAFEF00D); inv(5); cam_if.read_addr_i = 4'd5; step();
    step();
    @(negedge clk);
    chk("wr_inv_valid", 32'(cam_if.read_valid_o), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin wr(i, 32'h1000 + 32'(i)); step(); end
    @(negedge clk);
    chk("fill_full", 32'(cam_if.full_o), 32'd1);
    chk("fill_free", 32'(cam_if.free_addr_o), 32'd0);
    inv(11); step();
    @(negedge clk);
    chk("inv11_full", 32'(cam_if.full_o), 32'd0);
    chk("inv11_free", 32'(cam_if.free_addr_o), 32'd11);
    wr(11, 32'h0B0B0B0B); inv(4); cam_if.read_addr_i = 4'd4; step();
    @(negedge clk);
    chk("split_free", 32'(cam_if.free_addr_o), 32'd4);
    srch(32'h1004); step();
    expect_search("inv_keep", 0, 0, 0);
    chk("inv_keep_data", cam_if.read_data_o, 32'h1004);
    chk("inv_keep_valid", 32'(cam_if.read_valid_o), 32'd0);

    srch(32'h1007); step();
    @(negedge clk);
    chk("pre_rst_done", 32'(cam_if.search_done_o), 32'd1);
    reset = 1'b1; srch(32'h1007); step();
    @(negedge clk);
    chk("rst_done", 32'(cam_if.search_done_o), 32'd0);
    chk("rst_hit", 32'(cam_if.search_hit_o), 32'd0);
    chk("rst_full", 32'(cam_if.full_o), 32'd0);
    reset = 1'b0;

`ifdef CAM_SEARCH_MASK_EN
    wr(4, 32'h0000ABCD); step();
    srch(32'hFFFFABCD); cam_if.search_mask_i = 32'hFFFF0000; step();
    expect_search("mask_hi", 1, 4, 0);
    srch(32'hFFFFABCD); cam_if.search_mask_i = 32'h0; step();
    expect_search("mask_none", 0, 0, 0);
    wr(9, 32'h1234ABCD); step();
    srch(32'h0); cam_if.search_mask_i = 32'hFFFFFFFF; step();
    expect_search("mask_all", 1, 4, 1);
    cam_if.search_mask_i = 32'h0;
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
